// File: rtl/traffic_generator_gmii_burst.sv
// Burst-mode GMII frame generator: replays a 32-bit-wide frame template MSB byte first,
// grouped into bursts with separate inter-frame / inter-burst gaps and optional sequence field.
module traffic_generator_gmii_burst #(
  parameter int unsigned BUF_ADDR_WIDTH = 9,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      start,
  input  logic                      stop,
  input  logic [BUF_ADDR_WIDTH+1:0] frame_size,
  input  logic [CNT_WIDTH-1:0]      interframe_gap,
  input  logic [CNT_WIDTH-1:0]      interburst_gap,
  input  logic [CNT_WIDTH-1:0]      frames_per_burst,
  input  logic [CNT_WIDTH-1:0]      total_frames,
  input  logic                      seq_en,
  input  logic [BUF_ADDR_WIDTH+1:0] seq_offset,
  output logic [BUF_ADDR_WIDTH-1:0] buf_addr,
  input  logic [31:0]               buf_data,
  output logic [7:0]                gmii_d,
  output logic                      gmii_en,
  output logic                      gmii_er,
  output logic                      busy,
  output logic                      done,
  output logic [CNT_WIDTH-1:0]      frame_count
);

  localparam int unsigned FS_W = BUF_ADDR_WIDTH + 2;

  typedef enum logic [1:0] {IDLE, PREFETCH, DATA, GAP} state_t;

  state_t state, next_state;

  logic [FS_W-1:0]      cfg_frame_size, cfg_seq_offset;
  logic [CNT_WIDTH-1:0] cfg_ifg, cfg_ibg, cfg_fpb, cfg_total;
  logic                 cfg_seq_en;

  logic [FS_W-1:0]      byte_idx;
  logic [CNT_WIDTH-1:0] fc, burst_idx, gap_cnt;
  logic                 stop_seen, done_pend;

  logic                 accept_c, last_c, end_run_c, burst_end_c, gap_stop_c, seq_hit_c;
  logic [CNT_WIDTH-1:0] fc_next_c, gap_sel_c, gap_load_c;
  logic [FS_W-1:0]      seq_rel_c;
  logic [31:0]          seq_word_c;
  logic [7:0]           tx_byte_c;

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (accept_c) next_state = PREFETCH;
      PREFETCH: next_state = DATA;
      DATA:     if (last_c) next_state = end_run_c ? IDLE : GAP;
      GAP: begin
        if (gap_stop_c)              next_state = IDLE;
        else if (gap_cnt == '0)      next_state = PREFETCH;
      end
      default:  next_state = IDLE;
    endcase
  end

  // Decode: frame end, run end, gap selection and the outgoing byte
  always_comb begin
    accept_c    = (state == IDLE) && start && !busy &&
                  (frame_size != '0) && (frames_per_burst != '0);
    last_c      = (state == DATA) && (byte_idx == cfg_frame_size - FS_W'(1));
    fc_next_c   = fc + CNT_WIDTH'(1);
    end_run_c   = stop_seen || stop || ((cfg_total != '0) && (fc_next_c == cfg_total));
    burst_end_c = (burst_idx + CNT_WIDTH'(1)) == cfg_fpb;
    gap_sel_c   = burst_end_c ? cfg_ibg : cfg_ifg;
    gap_load_c  = (gap_sel_c < CNT_WIDTH'(2)) ? '0 : gap_sel_c - CNT_WIDTH'(2);
    gap_stop_c  = (state == GAP) && (stop || stop_seen);
    seq_rel_c   = byte_idx - cfg_seq_offset;
    seq_hit_c   = cfg_seq_en && (byte_idx >= cfg_seq_offset) && (seq_rel_c < FS_W'(4));
    seq_word_c  = 32'(fc);
    tx_byte_c   = 8'h00;
    if (seq_hit_c) begin
      case (seq_rel_c[1:0])
        2'd0:    tx_byte_c = seq_word_c[31:24];
        2'd1:    tx_byte_c = seq_word_c[23:16];
        2'd2:    tx_byte_c = seq_word_c[15:8];
        default: tx_byte_c = seq_word_c[7:0];
      endcase
    end else begin
      case (byte_idx[1:0])
        2'd0:    tx_byte_c = buf_data[31:24];
        2'd1:    tx_byte_c = buf_data[23:16];
        2'd2:    tx_byte_c = buf_data[15:8];
        default: tx_byte_c = buf_data[7:0];
      endcase
    end
  end

  // Datapath and registered outputs; done/busy/frame_count trail the FSM by one cycle
  // so they line up with the byte stream on gmii_d.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cfg_frame_size <= '0;
      cfg_seq_offset <= '0;
      cfg_ifg        <= '0;
      cfg_ibg        <= '0;
      cfg_fpb        <= '0;
      cfg_total      <= '0;
      cfg_seq_en     <= 1'b0;
      byte_idx       <= '0;
      fc             <= '0;
      burst_idx      <= '0;
      gap_cnt        <= '0;
      stop_seen      <= 1'b0;
      done_pend      <= 1'b0;
      buf_addr       <= '0;
      gmii_d         <= '0;
      gmii_en        <= 1'b0;
      gmii_er        <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      frame_count    <= '0;
    end else begin
      done_pend   <= last_c && end_run_c;
      done        <= done_pend || gap_stop_c;
      busy        <= (next_state != IDLE) || last_c;
      frame_count <= fc;
      gmii_en     <= (state == DATA);
      gmii_d      <= (state == DATA) ? tx_byte_c : 8'h00;
      gmii_er     <= 1'b0;
      stop_seen   <= (state == IDLE) ? (accept_c && stop) : (stop_seen || stop);
      case (state)
        IDLE: begin
          if (accept_c) begin
            cfg_frame_size <= frame_size;
            cfg_seq_offset <= seq_offset;
            cfg_ifg        <= interframe_gap;
            cfg_ibg        <= interburst_gap;
            cfg_fpb        <= frames_per_burst;
            cfg_total      <= total_frames;
            cfg_seq_en     <= seq_en;
            fc             <= '0;
            burst_idx      <= '0;
            buf_addr       <= '0;
          end
        end
        PREFETCH: byte_idx <= '0;
        DATA: begin
          byte_idx <= byte_idx + FS_W'(1);
          if (byte_idx[1:0] == 2'd2) buf_addr <= buf_addr + BUF_ADDR_WIDTH'(1);
          if (last_c) begin
            fc        <= fc_next_c;
            gap_cnt   <= gap_load_c;
            burst_idx <= burst_end_c ? '0 : burst_idx + CNT_WIDTH'(1);
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt - CNT_WIDTH'(1);
          if (gap_cnt == '0) buf_addr <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_generator_gmii_burst.sv
// Scoreboard bench for traffic_generator_gmii_burst: expected bytes and gap lengths are
// queued per run and consumed as the DUT drives gmii_en.
module tb_traffic_generator_gmii_burst;
  localparam int unsigned AW = 9;
  localparam int unsigned CW = 32;

  logic          clk = 1'b0;
  logic          resetn, start, stop, seq_en;
  logic [AW+1:0] frame_size, seq_offset;
  logic [CW-1:0] interframe_gap, interburst_gap, frames_per_burst, total_frames;
  logic [AW-1:0] buf_addr;
  logic [31:0]   buf_data;
  logic [7:0]    gmii_d;
  logic          gmii_en, gmii_er, busy, done;
  logic [CW-1:0] frame_count;

  traffic_generator_gmii_burst #(.BUF_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .resetn(resetn), .start(start), .stop(stop),
    .frame_size(frame_size), .interframe_gap(interframe_gap),
    .interburst_gap(interburst_gap), .frames_per_burst(frames_per_burst),
    .total_frames(total_frames), .seq_en(seq_en), .seq_offset(seq_offset),
    .buf_addr(buf_addr), .buf_data(buf_data), .gmii_d(gmii_d), .gmii_en(gmii_en),
    .gmii_er(gmii_er), .busy(busy), .done(done), .frame_count(frame_count)
  );

  always #4 clk = ~clk;

  logic [31:0] mem [0:(1<<AW)-1];
  always @(posedge clk) buf_data <= mem[buf_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp_q[$];
  int         gap_q[$];
  int         n_cmp = 0, n_err = 0;
  int         bytes_seen, exp_total, low_run, first_en_cyc, last_en_cyc, start_cyc, done_cyc;
  bit         seen_en;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic monitor_step();
    if (gmii_en) begin
      if (!seen_en) first_en_cyc = cyc;
      else if (low_run > 0) begin
        if (gap_q.size() == 0) chk("gap_extra", low_run, 0);
        else chk("gap_len", low_run, gap_q.pop_front());
      end
      if (exp_q.size() == 0) chk("byte_extra", bytes_seen + 1, exp_total);
      else chk("byte", gmii_d, exp_q.pop_front());
      chk("gmii_er", gmii_er, 0);
      bytes_seen++;
      last_en_cyc = cyc;
      seen_en = 1'b1;
      low_run = 0;
    end else if (seen_en) low_run++;
  endtask

  task automatic run_test(input int fs, input int ifg, input int ibg, input int fpb,
                          input int total, input bit seqen, input int seqoff,
                          input int nfr, input int stop_byte, input bit stop_now);
    logic [31:0] w;
    logic [7:0]  eb;
    int          g;
    bit          got_done;
    frame_size       = (AW+2)'(fs);
    interframe_gap   = CW'(ifg);
    interburst_gap   = CW'(ibg);
    frames_per_burst = CW'(fpb);
    total_frames     = CW'(total);
    seq_en           = seqen;
    seq_offset       = (AW+2)'(seqoff);
    exp_q.delete();
    gap_q.delete();
    for (int k = 0; k < nfr; k++) begin
      if (k > 0) begin
        g = (k % fpb == 0) ? ibg : ifg;
        gap_q.push_back(g < 2 ? 2 : g);
      end
      for (int b = 0; b < fs; b++) begin
        if (seqen && b >= seqoff && b < seqoff + 4) eb = 8'(k >> (8 * (3 - (b - seqoff))));
        else begin
          w  = mem[b / 4];
          eb = 8'(w >> (8 * (3 - b % 4)));
        end
        exp_q.push_back(eb);
      end
    end
    exp_total = fs * nfr;
    bytes_seen = 0; seen_en = 1'b0; low_run = 0; first_en_cyc = -1; last_en_cyc = -1;
    done_cyc = -1;
    @(negedge clk); #1;
    start = 1'b1; stop = stop_now; start_cyc = cyc;
    @(negedge clk); #1;
    start = 1'b0;
    chk("busy_rise", busy, 1);
    got_done = 1'b0;
    for (int t = 0; t < 20000 && !got_done; t++) begin
      if (stop_byte >= 0 && bytes_seen == stop_byte + 1) stop = 1'b1;
      if (done) begin got_done = 1'b1; done_cyc = cyc; end
      else begin @(negedge clk); #1; end
    end
    chk("done_seen", got_done, 1);
    chk("done_cycle", done_cyc, last_en_cyc + 1);
    chk("busy_fall", busy, 0);
    chk("frame_count", frame_count, nfr);
    chk("first_en", first_en_cyc, start_cyc + 3);
    stop = 1'b0;
    @(negedge clk); #1;
    chk("done_pulse", done, 0);
    repeat (30) @(negedge clk);
    #1;
    chk("byte_total", bytes_seen, exp_total);
    chk("gap_left", gap_q.size(), 0);
    chk("byte_left", exp_q.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
    mem[0] = 32'h01020304;
    mem[1] = 32'h05060708;
    resetn = 1'b0; start = 1'b0; stop = 1'b0; seq_en = 1'b0;
    frame_size = '0; seq_offset = '0; interframe_gap = '0; interburst_gap = '0;
    frames_per_burst = '0; total_frames = '0;
    exp_total = 0; bytes_seen = 0; seen_en = 1'b0; low_run = 0;
    fork
      forever begin
        @(negedge clk);
        monitor_step();
      end
    join_none
    repeat (3) @(negedge clk);
    chk("rst_en", gmii_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fc", frame_count, 0);
    chk("rst_addr", buf_addr, 0);
    resetn = 1'b1;
    @(negedge clk);

    // start ignored when frame_size is zero
    frame_size = '0; frames_per_burst = CW'(1); total_frames = CW'(1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("ign_busy", busy, 0);
      chk("ign_done", done, 0);
      @(negedge clk);
    end

    run_test(6, 12, 12, 1, 1, 1'b0, 0, 1, -1, 1'b0);
    run_test(64, 12, 100, 3, 6, 1'b0, 0, 6, -1, 1'b0);
    run_test(8, 0, 1, 1, 0, 1'b0, 0, 4, 27, 1'b0);
    run_test(8, 5, 9, 2, 3, 1'b1, 2, 3, -1, 1'b0);
    run_test(64, 12, 12, 1, 0, 1'b0, 0, 1, 10, 1'b0);
    run_test(8, 20, 20, 1, 0, 1'b0, 0, 2, 15, 1'b0);
    run_test(10, 4, 4, 1, 0, 1'b0, 0, 1, -1, 1'b1);

    // synchronous reset in the middle of a frame
    frame_size = (AW+2)'(64); total_frames = CW'(1); frames_per_burst = CW'(1);
    seq_en = 1'b0; exp_q.delete(); gap_q.delete(); exp_total = 64;
    bytes_seen = 0; seen_en = 1'b0; low_run = 0;
    for (int b = 0; b < 64; b++) exp_q.push_back(8'(mem[b / 4] >> (8 * (3 - b % 4))));
    @(negedge clk); #1;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    for (int t = 0; t < 200 && bytes_seen < 6; t++) begin @(negedge clk); #1; end
    chk("pre_rst_bytes", bytes_seen, 6);
    resetn = 1'b0;
    @(negedge clk); #1;
    chk("mid_rst_en", gmii_en, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_fc", frame_count, 0);
    chk("mid_rst_addr", buf_addr, 0);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    run_test(5, 3, 3, 1, 1, 1'b0, 0, 1, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/traffic_generator_gmii_burst.md
# traffic_generator_gmii_burst

Parametrised burst-mode GMII frame generator, the next generation of the single-frame GMII traffic generator. It replays a frame template held in a 32-bit-wide frame buffer, transmitting MSB byte first. Transmission is organised into bursts, with separate inter-frame and inter-burst gaps, a total frame count, and optional in-frame sequence number insertion. It sits between the CPU register/BRAM block (config inputs, buffer read port) and the GMII TX pins.

## Interface
- BUF_ADDR_WIDTH, 9: frame buffer word address width. Maximum frame length is 4·2^BUF_ADDR_WIDTH bytes.
- CNT_WIDTH, 32: width of gap, frame and burst counters.
- clk  in  1  GMII TX clock (125 MHz).
- resetn  in  1  synchronous, active-low reset on clk.
- start  in  1  one-cycle pulse; begins a run when idle.
- stop  in  1  level or pulse; ends the run after the current frame.
- frame_size  in  BUF_ADDR_WIDTH+2  frame length in bytes.
- interframe_gap  in  CNT_WIDTH  idle cycles between frames inside a burst.
- interburst_gap  in  CNT_WIDTH  idle cycles between bursts.
- frames_per_burst  in  CNT_WIDTH  frames per burst.
- total_frames  in  CNT_WIDTH  frames per run; 0 = continuous.
- seq_en  in  1  enables sequence number insertion.
- seq_offset  in  BUF_ADDR_WIDTH+2  byte offset of the 4-byte sequence field.
- buf_addr  out  BUF_ADDR_WIDTH  frame buffer word address; read latency is 1 cycle.
- buf_data  in  32  frame buffer word; byte 0 = bits [31:24].
- gmii_d  out  8  TX data, registered.
- gmii_en  out  1  TX enable, registered.
- gmii_er  out  1  TX error; always 0, registered.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a run ends.
- frame_count  out  CNT_WIDTH  frames completed in the current/last run.

## Operation
- States: IDLE, PREFETCH, DATA, GAP.
- IDLE: outputs quiet.
  - start is accepted only if frame_size≠0 and frames_per_burst≠0; otherwise it is ignored, with no done pulse.
  - On accept, latch all config inputs, clear frame_count and the burst index, set buf_addr=0, and go to PREFETCH.
- PREFETCH: one cycle; go to DATA. Byte index i=0.
- DATA: one byte per cycle.
  - Output byte = buf_data lane i[1:0], MSB lane first.
  - buf_addr increments in the cycle where i[1:0]==2.
  - If seq_en and seq_offset ≤ i < seq_offset+4, emit byte (i−seq_offset) of frame_count, big-endian, instead of the buffer byte. Bytes falling beyond frame_size are simply not sent.
  - When i == frame_size−1: increment frame_count, then:
    - done condition (stop seen since the run started, or total_frames≠0 and frame_count reaches total_frames) → IDLE, done=1;
    - else → GAP, using the interburst gap if the burst index completes frames_per_burst (burst index then wraps to 0), otherwise the interframe gap.
- GAP: count g−1 cycles with g = max(selected gap, 2); then set buf_addr=0 and go to PREFETCH. stop seen during GAP → IDLE, done=1.
- Frames are never truncated by stop. start while busy is ignored.
- Counter arithmetic is unsigned CNT_WIDTH and wraps modulo 2^CNT_WIDTH. frame_size beyond the maximum frame length is clamped to the maximum.

## Timing
- Reset (synchronous, any state, including mid-frame): next cycle all outputs are 0 (gmii_d, gmii_en, gmii_er, busy, done, frame_count, buf_addr) and the state is IDLE.
- start high in cycle 0 → busy in cycle 1, gmii_en first high in cycle 3 carrying byte 0.
- gmii_en stays high for exactly frame_size consecutive cycles per frame.
- Between frames, gmii_en is low for exactly max(gap,2) cycles; the PREFETCH cycle is included in the gap.
- done pulses in the cycle after the last gmii_en=1 cycle of the run (or the cycle after stop is sampled in GAP). busy falls in that same cycle.
- frame_count is updated in the cycle after the frame's last byte appears on gmii_d.
- stop and start sampled in the same cycle while IDLE: start is accepted and stop is latched, so exactly one frame is sent.

## Test plan
- Buffer words 0x01020304, 0x05060708; frame_size=6, total_frames=1, gap=12 → gmii_d = 01 02 03 04 05 06 with gmii_en high for 6 cycles starting cycle 3; done 1 cycle after; frame_count=1.
- frame_size=64, frames_per_burst=3, total_frames=6, interframe_gap=12, interburst_gap=100 → en-low runs of 12, 12, 100, 12, 12; done after frame 6.
- interframe_gap=0, frames_per_burst=1 → each en-low run is exactly 2 cycles; total_frames=0 runs until stop.
- seq_en=1, seq_offset=2, frame_size=8, total_frames=3 → bytes 2..5 of the frames are 00000000, 00000001, 00000002; other bytes come from the buffer.
- stop asserted at byte 10 of a 64-byte frame → all 64 bytes are sent, then done, with no further en; a second start then restarts with frame_count=0.
- resetn low at byte 5 → next cycle gmii_en=0, busy=0; start after reset sends the frame from byte 0.
